// File: rtl/control_multicycle_pkg.sv
// mips_pkg: opcode constants, FSM state encodings and datapath mux codes
// shared by the multicycle controller, its output decoder and the datapath.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Both lw and sw share the MEMADR address-computation step.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/control_multicycle_if.sv
// Controller <-> datapath bundle. master = controller (drives control
// strobes), slave = datapath (drives opcode, zero flag, memory ready).
interface control_multicycle_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite;
  logic       pcwritecond;
  logic       pc_en;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsource;
  logic       branch_ne;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pcwrite, pcwritecond, pc_en, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
           branch_ne, instr_done, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pcwrite, pcwritecond, pc_en, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
           branch_ne, instr_done, illegal_op, state
  );
endinterface

// File: rtl/control_multicycle_outdecode.sv
// mc_outdecode: combinational state (+opcode, mem_ready, zero) to datapath
// control strobes. All outputs are held at 0 while i_rst_n is low so an
// in-flight memory access is abandoned in the same cycle reset asserts.
// Optional JUMP decoding is enabled by CONTROL_MC_JUMP_EN.
module mc_outdecode
  import mips_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  input  logic       i_zero,
  output logic       o_pcwrite,
  output logic       o_pcwritecond,
  output logic       o_pc_en,
  output logic       o_iord,
  output logic       o_memread,
  output logic       o_memwrite,
  output logic       o_irwrite,
  output logic       o_memtoreg,
  output logic       o_regdst,
  output logic       o_regwrite,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_aluop,
  output logic [1:0] o_pcsource,
  output logic       o_branch_ne,
  output logic       o_instr_done,
  output logic       o_illegal_op,
  output logic [3:0] o_state
);

  // Moore decode of the current state; unlisted strobes stay at 0.
  always_comb begin
    o_pcwrite     = 1'b0;
    o_pcwritecond = 1'b0;
    o_pc_en       = 1'b0;
    o_iord        = 1'b0;
    o_memread     = 1'b0;
    o_memwrite    = 1'b0;
    o_irwrite     = 1'b0;
    o_memtoreg    = 1'b0;
    o_regdst      = 1'b0;
    o_regwrite    = 1'b0;
    o_alusrca     = 1'b0;
    o_alusrcb     = ALUSRCB_RT;
    o_aluop       = ALUOP_ADD;
    o_pcsource    = PCSRC_ALU;
    o_branch_ne   = 1'b0;
    o_instr_done  = 1'b0;
    o_illegal_op  = 1'b0;
    o_state       = 4'd0;
    if (i_rst_n) begin
      o_state = i_state;
      case (i_state)
        S_FETCH: begin
          o_memread = 1'b1;
          o_alusrcb = ALUSRCB_FOUR;
          o_irwrite = i_mem_ready;
          o_pcwrite = i_mem_ready;
        end
        S_DECODE: begin
          o_alusrcb = ALUSRCB_IMMSH;
          case (i_opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI: ;
`ifdef CONTROL_MC_JUMP_EN
            OP_J: ;
`else
            OP_J: begin
              o_illegal_op = 1'b1;
              o_instr_done = 1'b1;
            end
`endif
            default: begin
              o_illegal_op = 1'b1;
              o_instr_done = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          o_alusrca = 1'b1;
          o_alusrcb = ALUSRCB_IMM;
        end
        S_MEMRD: begin
          o_memread = 1'b1;
          o_iord    = 1'b1;
        end
        S_MEMWB: begin
          o_regwrite   = 1'b1;
          o_memtoreg   = 1'b1;
          o_instr_done = 1'b1;
        end
        S_MEMWR: begin
          o_memwrite   = 1'b1;
          o_iord       = 1'b1;
          o_instr_done = i_mem_ready;
        end
        S_EXEC: begin
          o_alusrca = 1'b1;
          o_alusrcb = ALUSRCB_RT;
          o_aluop   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          o_regwrite   = 1'b1;
          o_regdst     = 1'b1;
          o_instr_done = 1'b1;
        end
        S_BRANCH: begin
          o_alusrca     = 1'b1;
          o_alusrcb     = ALUSRCB_RT;
          o_aluop       = ALUOP_SUB;
          o_pcwritecond = 1'b1;
          o_pcsource    = PCSRC_ALUOUT;
          o_branch_ne   = (i_opcode == OP_BNE);
          o_instr_done  = 1'b1;
        end
        S_ADDIEX: begin
          o_alusrca = 1'b1;
          o_alusrcb = ALUSRCB_IMM;
          o_aluop   = ALUOP_ADD;
        end
        S_ADDIWB: begin
          o_regwrite   = 1'b1;
          o_instr_done = 1'b1;
        end
`ifdef CONTROL_MC_JUMP_EN
        S_JUMP: begin
          o_pcwrite    = 1'b1;
          o_pcsource   = PCSRC_JUMP;
          o_instr_done = 1'b1;
        end
`else
        S_JUMP: ;
`endif
        default: ;
      endcase
      // bne inverts the sense of the zero flag.
      o_pc_en = o_pcwrite | (o_pcwritecond & (i_zero ^ o_branch_ne));
    end
  end

endmodule

// File: rtl/control_multicycle.sv
// control_multicycle: Moore FSM sequencing the shared multicycle MIPS
// datapath through fetch/decode/execute/mem/writeback.
//   state  | meaning
//   FETCH  | read instruction at PC, PC+4; wait for memory ready
//   DECODE | branch target into ALUOut, dispatch on opcode
//   MEMADR | base + imm address for lw/sw
//   MEMRD  | data read at ALUOut; wait for memory ready
//   MEMWB  | MDR -> rt
//   MEMWR  | data write at ALUOut; wait for memory ready
//   EXEC   | R-type ALU op
//   ALUWB  | ALUOut -> rd
//   BRANCH | compare rs/rt, conditional PC load from ALUOut
//   ADDIEX | rs + imm
//   ADDIWB | ALUOut -> rt
//   JUMP   | PC <- jump target (only with CONTROL_MC_JUMP_EN)
// MEM_HANDSHAKE=0 treats memory as always ready.
module control_multicycle
  import mips_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  control_multicycle_if.master        bus
);

  state_t r_state;
  state_t w_next;
  logic   w_mem_ready;

  assign w_mem_ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state selection; unknown codes fall back to FETCH.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_RTYPE:       w_next = S_EXEC;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_ADDI:        w_next = S_ADDIEX;
`ifdef CONTROL_MC_JUMP_EN
          OP_J:           w_next = S_JUMP;
`else
          OP_J:           w_next = S_FETCH;
`endif
          default:        w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = w_mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  mc_outdecode u_outdecode (
    .i_state       (r_state),
    .i_rst_n       (rst_n),
    .i_opcode      (bus.opcode),
    .i_mem_ready   (w_mem_ready),
    .i_zero        (bus.zero),
    .o_pcwrite     (bus.pcwrite),
    .o_pcwritecond (bus.pcwritecond),
    .o_pc_en       (bus.pc_en),
    .o_iord        (bus.iord),
    .o_memread     (bus.memread),
    .o_memwrite    (bus.memwrite),
    .o_irwrite     (bus.irwrite),
    .o_memtoreg    (bus.memtoreg),
    .o_regdst      (bus.regdst),
    .o_regwrite    (bus.regwrite),
    .o_alusrca     (bus.alusrca),
    .o_alusrcb     (bus.alusrcb),
    .o_aluop       (bus.aluop),
    .o_pcsource    (bus.pcsource),
    .o_branch_ne   (bus.branch_ne),
    .o_instr_done  (bus.instr_done),
    .o_illegal_op  (bus.illegal_op),
    .o_state       (bus.state)
  );

endmodule
